// File: rtl/stream_mux_n_to_1.sv
// -----------------------------------------------------------------------------
// stream_mux_n_to_1
//
// Purpose:
//   N-to-1 valid/ready stream multiplexer. The block picks one of NUM_INPUTS
//   producer channels each cycle, either by fixed priority or by round robin,
//   and registers the winning beat into a single output stage. It is meant to
//   sit in front of a CDC synchroniser or FIFO write port so that several
//   producers in the same clock domain can share one crossing channel.
//
// Parameters:
//   INPUT_BIT_LENGTH  data bits per channel (values below 1 behave as 1)
//   NUM_INPUTS        number of input channels, 1..32
//   ARB_MODE          0 = fixed priority (lowest index wins), 1 = round robin
//   SEL_W             derived index width, max(1, $clog2(NUM_INPUTS))
//
// Ports:
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_data    in   packed channel data, channel i at [i*W +: W]
//   in_valid   in   per-channel valid
//   in_ready   out  per-channel ready (combinational, at most one bit high)
//   out_data   out  registered data of the granted beat
//   out_sel    out  registered index of the channel that supplied out_data
//   out_valid  out  output stage holds a beat
//   out_ready  in   downstream accepts the held beat
// -----------------------------------------------------------------------------
module stream_mux_n_to_1 #(
   parameter int INPUT_BIT_LENGTH = 1,
   parameter int NUM_INPUTS       = 4,
   parameter int ARB_MODE         = 0,
   localparam int W               = (INPUT_BIT_LENGTH < 1) ? 1 : INPUT_BIT_LENGTH,
   localparam int SEL_W           = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_INPUTS*W-1:0] in_data,
   input  logic [NUM_INPUTS-1:0]   in_valid,
   output logic [NUM_INPUTS-1:0]   in_ready,
   output logic [W-1:0]            out_data,
   output logic [SEL_W-1:0]        out_sel,
   output logic                    out_valid,
   input  logic                    out_ready
);

   // --------------------------------------------------------------------------
   // Arbitration helper.
   // Scans channels starting at 'start' and wrapping modulo NUM_INPUTS.
   // Returns {found, index}. The scan runs from the farthest offset down to the
   // nearest one so that the last hit (the nearest valid channel) wins.
   // With start = 0 this degenerates to lowest-index-first priority.
   // --------------------------------------------------------------------------
   function automatic logic [SEL_W:0] f_pick(
      input logic [NUM_INPUTS-1:0] valid,
      input logic [SEL_W-1:0]      start
   );
      logic [SEL_W:0] res;
      int             c;
      res = '0;
      for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
         c   = int'(start) + k;
         c   = (c >= NUM_INPUTS) ? (c - NUM_INPUTS) : c;
         res = valid[c] ? {1'b1, SEL_W'(c)} : res;
      end
      return res;
   endfunction

   // Output stage and round-robin pointer state
   logic [W-1:0]            r_data;
   logic [SEL_W-1:0]        r_sel;
   logic                    r_valid;
   logic [SEL_W-1:0]        r_ptr;

   // Combinational arbitration results
   logic                    w_load_en;
   logic                    w_any_valid;
   logic                    w_in_hs;
   logic [SEL_W:0]          w_pick;
   logic [SEL_W-1:0]        w_grant_idx;
   logic [SEL_W-1:0]        w_search_start;
   logic [SEL_W-1:0]        w_ptr_nxt;
   logic [NUM_INPUTS-1:0]   w_grant_oh;
   logic [W-1:0]            w_grant_data;

   // The output stage can take a new beat when empty or drained this cycle
   assign w_load_en = ~r_valid | out_ready;

   // Fixed-priority mode always searches from channel 0; the pointer is unused
   assign w_search_start = (ARB_MODE == 1) ? r_ptr : {SEL_W{1'b0}};

   // Pick the winner among valid channels
   always_comb begin
      w_pick      = f_pick(in_valid, w_search_start);
      w_any_valid = w_pick[SEL_W];
      w_grant_idx = w_pick[SEL_W-1:0];
   end

   // One-hot grant; only a valid channel can ever appear here
   always_comb begin
      w_grant_oh = '0;
      if (w_any_valid) begin
         w_grant_oh = NUM_INPUTS'(1'b1) << w_grant_idx;
      end else begin
         w_grant_oh = '0;
      end
   end

   // Ready is forced low during reset: load_en alone would be high there
   // because the empty output stage reads as able to load.
   assign in_ready = w_grant_oh & {NUM_INPUTS{w_load_en & rst_n}};

   // AND-OR select of the granted channel's data using the one-hot grant
   always_comb begin
      w_grant_data = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         w_grant_data = w_grant_oh[i] ? in_data[i*W +: W] : w_grant_data;
      end
   end

   // An input handshake happens exactly when a grant exists and load is open
   assign w_in_hs = w_load_en & w_any_valid;

   // Pointer moves to the channel after the winner, wrapping at the last one
   always_comb begin
      w_ptr_nxt = '0;
      if (int'(w_grant_idx) == (NUM_INPUTS - 1)) begin
         w_ptr_nxt = '0;
      end else begin
         w_ptr_nxt = w_grant_idx + SEL_W'(1);
      end
   end

   // Output stage: load the winner, drain when accepted, otherwise hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data  <= '0;
         r_sel   <= '0;
         r_valid <= 1'b0;
      end else if (w_in_hs) begin
         r_data  <= w_grant_data;
         r_sel   <= w_grant_idx;
         r_valid <= 1'b1;
      end else if (out_ready) begin
         // Drained with nothing to refill: data and index keep their values
         r_valid <= 1'b0;
      end else begin
         r_data  <= r_data;
         r_sel   <= r_sel;
         r_valid <= r_valid;
      end
   end

   // Round-robin pointer: advances only on a completed input handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if ((ARB_MODE == 1) && w_in_hs) begin
         r_ptr <= w_ptr_nxt;
      end else begin
         r_ptr <= r_ptr;
      end
   end

   assign out_data  = r_data;
   assign out_sel   = r_sel;
   assign out_valid = r_valid;

endmodule

// File: tb/tb_stream_mux_n_to_1.sv
// -----------------------------------------------------------------------------
// tb_stream_mux_n_to_1
//
// Directed bench for stream_mux_n_to_1 with W=8, N=4. Two instances share the
// clock and reset: u_fp runs fixed priority, u_rr runs round robin. Each has
// its own data/valid/ready drive so phases can target one arbiter at a time.
// -----------------------------------------------------------------------------
module tb_stream_mux_n_to_1;

   localparam int W = 8;
   localparam int N = 4;

   logic           clk;
   logic           rst_n;

   logic [N*W-1:0] d0, d1;
   logic [N-1:0]   v0, v1;
   logic [N-1:0]   rdy0, rdy1;
   logic [W-1:0]   od0, od1;
   logic [1:0]     os0, os1;
   logic           ov0, ov1;
   logic           or0, or1;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] chd [4];
   int         exp_g [6];
   int         exp_s [3];
   logic [N-1:0] bp_v [5];

   stream_mux_n_to_1 #(.INPUT_BIT_LENGTH(W), .NUM_INPUTS(N), .ARB_MODE(0)) u_fp (
      .clk(clk), .rst_n(rst_n), .in_data(d0), .in_valid(v0), .in_ready(rdy0),
      .out_data(od0), .out_sel(os0), .out_valid(ov0), .out_ready(or0)
   );

   stream_mux_n_to_1 #(.INPUT_BIT_LENGTH(W), .NUM_INPUTS(N), .ARB_MODE(1)) u_rr (
      .clk(clk), .rst_n(rst_n), .in_data(d1), .in_valid(v1), .in_ready(rdy1),
      .out_data(od1), .out_sel(os1), .out_valid(ov1), .out_ready(or1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // advance to 1 time unit after the next rising edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      chd[0] = 8'hA0; chd[1] = 8'h11; chd[2] = 8'h22; chd[3] = 8'h33;
      exp_g[0] = 1; exp_g[1] = 2; exp_g[2] = 3; exp_g[3] = 0; exp_g[4] = 1; exp_g[5] = 2;
      exp_s[0] = 0; exp_s[1] = 2; exp_s[2] = 0;
      bp_v[0] = 4'b0001; bp_v[1] = 4'b0011; bp_v[2] = 4'b1111; bp_v[3] = 4'b1000; bp_v[4] = 4'b0101;

      rst_n = 1'b0;
      d0 = {chd[3], chd[2], chd[1], chd[0]};
      d1 = {chd[3], chd[2], chd[1], chd[0]};
      v0 = 4'b1111; v1 = 4'b1111;
      or0 = 1'b1; or1 = 1'b1;

      // ---- Reset with all inputs valid: everything stays at reset values
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("rst_ov0", 32'(ov0), 32'd0);
         chk("rst_od0", 32'(od0), 32'd0);
         chk("rst_os0", 32'(os0), 32'd0);
         chk("rst_rdy0", 32'(rdy0), 32'd0);
         chk("rst_rdy1", 32'(rdy1), 32'd0);
      end
      rst_n = 1'b1;
      #1;
      chk("rel_ov0", 32'(ov0), 32'd0);
      chk("rel_rdy0", 32'(rdy0), 32'b0001);
      chk("rel_rdy1", 32'(rdy1), 32'b0001);
      cyc();
      chk("first_ov0", 32'(ov0), 32'd1);
      chk("first_od0", 32'(od0), 32'hA0);
      chk("first_os0", 32'(os0), 32'd0);
      chk("first_ov1", 32'(ov1), 32'd1);
      chk("first_od1", 32'(od1), 32'hA0);

      // ---- Fixed priority: ch1 always beats ch3 while both valid
      v0 = 4'b1010; or0 = 1'b1;
      v1 = 4'b0000; or1 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("fp_rdy_ch1", 32'(rdy0), 32'b0010);
         cyc();
         chk("fp_os_ch1", 32'(os0), 32'd1);
         chk("fp_od_ch1", 32'(od0), 32'h11);
         chk("fp_ov_ch1", 32'(ov0), 32'd1);
      end
      v0 = 4'b1000;
      #1;
      chk("fp_rdy_ch3", 32'(rdy0), 32'b1000);
      cyc();
      chk("fp_os_ch3", 32'(os0), 32'd3);
      chk("fp_od_ch3", 32'(od0), 32'h33);
      v0 = 4'b0000;
      #1;
      chk("fp_rdy_idle", 32'(rdy0), 32'd0);
      cyc();
      chk("fp_drain_ov", 32'(ov0), 32'd0);
      chk("fp_drain_od", 32'(od0), 32'h33);
      chk("fp_drain_os", 32'(os0), 32'd3);

      // ---- Round robin, all valid: pointer is 1 after the first beat
      v1 = 4'b1111; or1 = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1;
         chk("rr_rdy", 32'(rdy1), 32'(4'b0001 << exp_g[i]));
         cyc();
         chk("rr_os", 32'(os1), 32'(exp_g[i]));
         chk("rr_od", 32'(od1), 32'(chd[exp_g[i]]));
         chk("rr_ov", 32'(ov1), 32'd1);
      end

      // ---- Sparse/wrap: ptr=3, only ch0 and ch2 valid
      v1 = 4'b0101;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("wrap_rdy", 32'(rdy1), 32'(4'b0001 << exp_s[i]));
         cyc();
         chk("wrap_os", 32'(os1), 32'(exp_s[i]));
         chk("wrap_od", 32'(od1), 32'(chd[exp_s[i]]));
      end

      // ---- Backpressure on the fixed-priority instance
      v0 = 4'b0100; or0 = 1'b0;
      #1;
      chk("bp_load_rdy", 32'(rdy0), 32'b0100);
      cyc();
      chk("bp_load_od", 32'(od0), 32'h22);
      chk("bp_load_os", 32'(os0), 32'd2);
      chk("bp_load_ov", 32'(ov0), 32'd1);
      d0 = {chd[3], chd[2], chd[1], 8'h5A};
      for (int i = 0; i < 5; i++) begin
         v0 = bp_v[i];
         #1;
         chk("bp_rdy", 32'(rdy0), 32'd0);
         cyc();
         chk("bp_od", 32'(od0), 32'h22);
         chk("bp_os", 32'(os0), 32'd2);
         chk("bp_ov", 32'(ov0), 32'd1);
      end
      v0 = 4'b0001; or0 = 1'b1;
      #1;
      chk("bp_release_rdy", 32'(rdy0), 32'b0001);
      cyc();
      chk("bp_refill_od", 32'(od0), 32'h5A);
      chk("bp_refill_os", 32'(os0), 32'd0);
      chk("bp_refill_ov", 32'(ov0), 32'd1);
      v0 = 4'b0000;
      #1;
      cyc();
      chk("bp_empty_ov", 32'(ov0), 32'd0);
      chk("bp_empty_od", 32'(od0), 32'h5A);

      // ---- Asynchronous reset in the middle of held beats
      d0 = {chd[3], chd[2], chd[1], chd[0]};
      v0 = 4'b0010; or0 = 1'b0;
      v1 = 4'b1111; or1 = 1'b0;
      #1;
      cyc();
      chk("pre_rst_od0", 32'(od0), 32'h11);
      chk("pre_rst_ov0", 32'(ov0), 32'd1);
      chk("pre_rst_os1", 32'(os1), 32'd0);
      chk("pre_rst_ov1", 32'(ov1), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_ov0", 32'(ov0), 32'd0);
      chk("arst_od0", 32'(od0), 32'd0);
      chk("arst_os0", 32'(os0), 32'd0);
      chk("arst_ov1", 32'(ov1), 32'd0);
      chk("arst_rdy0", 32'(rdy0), 32'd0);
      chk("arst_rdy1", 32'(rdy1), 32'd0);
      cyc();
      cyc();
      chk("arst_hold_ov0", 32'(ov0), 32'd0);
      chk("arst_hold_ov1", 32'(ov1), 32'd0);
      v0 = 4'b0000; v1 = 4'b0000; or0 = 1'b1; or1 = 1'b1;
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         cyc();
         chk("post_rst_ov0", 32'(ov0), 32'd0);
         chk("post_rst_ov1", 32'(ov1), 32'd0);
      end
      v0 = 4'b0001; v1 = 4'b1111;
      #1;
      chk("post_rst_rdy0", 32'(rdy0), 32'b0001);
      chk("post_rst_ptr", 32'(rdy1), 32'b0001);
      cyc();
      chk("post_rst_os1", 32'(os1), 32'd0);
      chk("post_rst_od1", 32'(od1), 32'hA0);
      chk("post_rst_od0", 32'(od0), 32'hA0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
